// File: rtl/sd_adc_sched_pkg.sv
// -----------------------------------------------------------------------------
// sd_adc_sched_pkg
// Shared definitions for the sigma-delta ADC conversion scheduler:
// default parameter widths, the round-counter width and the scheduler
// state encoding.
// -----------------------------------------------------------------------------
package sd_adc_sched_pkg;

    localparam int unsigned NUM_CH_DEF   = 4;
    localparam int unsigned PERIOD_W_DEF = 16;
    localparam int unsigned TO_W_DEF     = 12;
    localparam int unsigned CONV_CNT_W   = 16;

    // Explicit encodings keep the legacy state values visible in waveforms.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/sd_adc_sched_timer.sv
// -----------------------------------------------------------------------------
// sd_adc_sched_timer
// Free-running period counter for internally triggered conversion rounds.
// Counts 0..period-1 while run is high and pulses tick on the last count.
// period = 0 suppresses ticks. The compare is against the live period, so a
// period reduced below the current count wraps on the next cycle.
//
// Ports:
//   clk_adc      in   ADC clock
//   reset_adc_n  in   asynchronous active-low reset
//   i_clear      in   synchronous clear of the count
//   i_run        in   count enable (count held at 0 while low)
//   i_period     in   period in clk_adc cycles
//   o_tick       out  one-cycle tick on the last count of the period
// -----------------------------------------------------------------------------
module sd_adc_sched_timer #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk_adc,
    input  logic                reset_adc_n,
    input  logic                i_clear,
    input  logic                i_run,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_tick
);

    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_count;
    logic                w_last;

    // ">=" rather than "==" so a shrunk period cannot strand the count.
    assign w_last = (i_period != '0) && (r_count >= (i_period - P_ONE));
    assign o_tick = i_run && !i_clear && w_last;

    always_ff @(posedge clk_adc or negedge reset_adc_n) begin
        if (!reset_adc_n) begin
            r_count <= '0;
        end else if (i_clear || !i_run || (i_period == '0)) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + P_ONE;
        end
    end

endmodule

// File: rtl/sd_adc_conv_sched.sv
// -----------------------------------------------------------------------------
// sd_adc_conv_sched
// Conversion scheduler for a bank of sigma-delta ADC channels. On a trigger
// event (external trig rising edge, or internal timer tick) it pulses
// start_adc to every enabled channel, waits for each channel's latch_en,
// and closes the round with a one-cycle done pulse. Overrun and timeout are
// reported as sticky flags.
//
// Ports:
//   clk_adc, reset_adc_n   clock, asynchronous active-low reset
//   enable                 scheduler enable (level)
//   mode                   0: external trig, 1: internal timer
//   period                 timer period, 0 disables timer triggers
//   trig                   external trigger level (rising edge = event)
//   ch_en                  channel enable mask, sampled at the event
//   timeout                max WAIT cycles, 0 = no timeout
//   clr_err                clears overrun / timeout_err
//   latch_en               per-channel result-latched strobe
//   start_adc              registered per-channel start pulse
//   busy                   high in START, WAIT or DONE
//   done                   registered one-cycle end-of-round pulse
//   done_mask              channels that latched in the last round
//   overrun                sticky: event arrived while busy
//   timeout_err            sticky: round ended by timeout
//   conv_count             completed-round counter (wraps)
// -----------------------------------------------------------------------------
module sd_adc_conv_sched
    import sd_adc_sched_pkg::*;
#(
    parameter int unsigned NUM_CH   = NUM_CH_DEF,
    parameter int unsigned PERIOD_W = PERIOD_W_DEF,
    parameter int unsigned TO_W     = TO_W_DEF
) (
    input  logic                  clk_adc,
    input  logic                  reset_adc_n,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [PERIOD_W-1:0]   period,
    input  logic                  trig,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic [TO_W-1:0]       timeout,
    input  logic                  clr_err,
    input  logic [NUM_CH-1:0]     latch_en,
    output logic [NUM_CH-1:0]     start_adc,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CH-1:0]     done_mask,
    output logic                  overrun,
    output logic                  timeout_err,
    output logic [CONV_CNT_W-1:0] conv_count
);

    localparam logic [TO_W-1:0]       TO_ONE  = TO_W'(1);
    localparam logic [CONV_CNT_W-1:0] CNT_ONE = CONV_CNT_W'(1);

    sched_state_t          r_state;
    logic                  r_trig_d;
    logic [NUM_CH-1:0]     r_active;
    logic [NUM_CH-1:0]     r_pending;
    logic [TO_W-1:0]       r_to_cnt;
    logic [NUM_CH-1:0]     r_start_adc;
    logic                  r_done;
    logic [NUM_CH-1:0]     r_done_mask;
    logic                  r_overrun;
    logic                  r_timeout_err;
    logic [CONV_CNT_W-1:0] r_conv_count;

    logic                  w_tick;
    logic                  w_event;
    logic                  w_busy;
    logic                  w_timer_clear;
    logic                  w_timer_run;
    logic [NUM_CH-1:0]     w_pend_next;
    logic                  w_to_hit;
    logic                  w_end_ok;
    logic                  w_end_to;

    sd_adc_sched_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk_adc     (clk_adc),
        .reset_adc_n (reset_adc_n),
        .i_clear     (w_timer_clear),
        .i_run       (w_timer_run),
        .i_period    (period),
        .o_tick      (w_tick)
    );

    assign w_timer_clear = (r_state == S_IDLE) && enable;
    assign w_timer_run   = (r_state != S_IDLE);

    assign w_event = mode ? w_tick : (trig & ~r_trig_d);
    assign w_busy  = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_DONE);

    // pending only ever holds active bits, so latch_en outside active is inert.
    assign w_pend_next = r_pending & ~latch_en;
    assign w_to_hit    = (timeout != '0) && (r_to_cnt == (timeout - TO_ONE));
    // Completion takes priority over a coincident timeout.
    assign w_end_ok    = (r_state == S_WAIT) && (w_pend_next == '0);
    assign w_end_to    = (r_state == S_WAIT) && (w_pend_next != '0) && w_to_hit;

    always_ff @(posedge clk_adc or negedge reset_adc_n) begin
        if (!reset_adc_n) begin
            r_state       <= S_IDLE;
            r_trig_d      <= 1'b0;
            r_active      <= '0;
            r_pending     <= '0;
            r_to_cnt      <= '0;
            r_start_adc   <= '0;
            r_done        <= 1'b0;
            r_done_mask   <= '0;
            r_conv_count  <= '0;
        end else begin
            r_trig_d    <= trig;
            r_start_adc <= '0;
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable) r_state <= S_ARM;
                end
                S_ARM: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end else if (w_event && (ch_en != '0)) begin
                        r_state     <= S_START;
                        r_active    <= ch_en;
                        r_pending   <= ch_en;
                        r_to_cnt    <= '0;
                        r_start_adc <= ch_en;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_pending <= w_pend_next;
                    r_to_cnt  <= r_to_cnt + TO_ONE;
                    if (w_end_ok || w_end_to) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_done_mask  <= r_active & ~w_pend_next;
                        r_conv_count <= r_conv_count + CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= enable ? S_ARM : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as clr_err wins.
    always_ff @(posedge clk_adc or negedge reset_adc_n) begin
        if (!reset_adc_n) begin
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_event && w_busy) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end

            if (w_end_to) begin
                r_timeout_err <= 1'b1;
            end else if (clr_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign start_adc   = r_start_adc;
    assign busy        = w_busy;
    assign done        = r_done;
    assign done_mask   = r_done_mask;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign conv_count  = r_conv_count;

endmodule
